prime_round_scorer: RTL and testbench

//  Upstream scoring stage for the high-score RAM block. Runs one game of ROUNDS

---
 rtl/prime_round_scorer.sv | 183 ++++++++++++++++++
 tb/tb_prime_round_scorer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_round_scorer.sv
// prime_round_scorer: runs one game of ROUNDS prime/not-prime guesses for a
// single player, scores each guess with a saturating score, then hands the
// final result to the high-score RAM stage with a one-cycle enable.
//
//   state      | meaning
//   IDLE       | waiting for Start with a legal player ID
//   WAIT_GUESS | Guess_Ready high, waiting for a guess
//   CHECK      | trial division, one divisor from {2,3,5,7,11} per cycle
//   SCORE      | verdict pulse, score and round update
//   DONE       | enable pulse to the RAM stage
//   HOLD       | lockout while the RAM stage finishes its write
module prime_round_scorer #(
  parameter int ROUNDS      = 10,
  parameter int CORRECT_PTS = 2,
  parameter int WRONG_PTS   = 1,
  parameter int HOLD_CYCLES = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] Player_ID_In,
  input  logic       Guess_Valid,
  input  logic [6:0] Number,
  input  logic       Guess_Is_Prime,
  output logic       Guess_Ready,
  output logic       Verdict_Valid,
  output logic       Verdict_Correct,
  output logic [3:0] Round_Count,
  output logic [6:0] Running_Score,
  output logic [2:0] Player_ID,
  output logic [6:0] Current_Score,
  output logic       enable,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE, WAIT_GUESS, CHECK, SCORE, DONE, HOLD
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] num_q;
  logic       claim_q;
  logic       is_prime_q;
  logic [2:0] idx;
  logic [3:0] hold_cnt;

  logic [6:0] divisor;
  logic [7:0] div_sq;
  logic       rem_zero;
  logic       check_done;
  logic       check_prime;
  logic       correct;
  logic [8:0] score_ext;
  logic [8:0] score_sum;
  logic [6:0] score_new;
  logic [3:0] round_new;
  logic       start_ok;

  assign start_ok  = Start && (Player_ID_In <= 3'd4);
  assign correct   = (is_prime_q == claim_q);
  assign round_new = Round_Count + 4'd1;

  // Current trial divisor and whether it divides the latched number.
  always_comb begin
    divisor  = 7'd11;
    rem_zero = 1'b0;
    case (idx)
      3'd0: begin divisor = 7'd2; rem_zero = ((num_q % 7'd2) == 7'd0); end
      3'd1: begin divisor = 7'd3; rem_zero = ((num_q % 7'd3) == 7'd0); end
      3'd2: begin divisor = 7'd5; rem_zero = ((num_q % 7'd5) == 7'd0); end
      3'd3: begin divisor = 7'd7; rem_zero = ((num_q % 7'd7) == 7'd0); end
      default: begin divisor = 7'd11; rem_zero = ((num_q % 7'd11) == 7'd0); end
    endcase
    div_sq = {1'b0, divisor} * {1'b0, divisor};
  end

  // One trial-division step; 11 is the last divisor needed below 128.
  always_comb begin
    check_done  = 1'b1;
    check_prime = 1'b0;
    if (num_q < 7'd2) begin
      check_prime = 1'b0;
    end else if (div_sq > {1'b0, num_q}) begin
      check_prime = 1'b1;
    end else if (num_q == divisor) begin
      check_prime = 1'b1;
    end else if (rem_zero) begin
      check_prime = 1'b0;
    end else if (idx == 3'd4) begin
      check_prime = 1'b1;
    end else begin
      check_done = 1'b0;
    end
  end

  // Saturating score update through a 9-bit intermediate.
  always_comb begin
    score_ext = {2'b00, Running_Score};
    score_sum = 9'd0;
    score_new = 7'd0;
    if (correct) begin
      score_sum = score_ext + 9'(CORRECT_PTS);
      score_new = (score_sum > 9'd127) ? 7'd127 : score_sum[6:0];
    end else if (score_ext < 9'(WRONG_PTS)) begin
      score_new = 7'd0;
    end else begin
      score_sum = score_ext - 9'(WRONG_PTS);
      score_new = score_sum[6:0];
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start_ok) state_nxt = WAIT_GUESS;
      WAIT_GUESS: if (Guess_Valid) state_nxt = CHECK;
      CHECK:      if (check_done) state_nxt = SCORE;
      SCORE:      state_nxt = (round_new == 4'(ROUNDS)) ? DONE : WAIT_GUESS;
      DONE:       state_nxt = HOLD;
      HOLD:       if (hold_cnt == 4'd0) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Datapath registers; Current_Score is captured with the last score so it
  // is already valid while enable is high.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      num_q         <= 7'd0;
      claim_q       <= 1'b0;
      is_prime_q    <= 1'b0;
      idx           <= 3'd0;
      hold_cnt      <= 4'd0;
      Round_Count   <= 4'd0;
      Running_Score <= 7'd0;
      Player_ID     <= 3'd0;
      Current_Score <= 7'd0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          Player_ID     <= Player_ID_In;
          Running_Score <= 7'd0;
          Round_Count   <= 4'd0;
          Current_Score <= 7'd0;
        end
        WAIT_GUESS: if (Guess_Valid) begin
          num_q   <= Number;
          claim_q <= Guess_Is_Prime;
          idx     <= 3'd0;
        end
        CHECK: begin
          if (check_done) is_prime_q <= check_prime;
          else            idx        <= idx + 3'd1;
        end
        SCORE: begin
          Running_Score <= score_new;
          Round_Count   <= round_new;
          if (round_new == 4'(ROUNDS)) Current_Score <= score_new;
        end
        DONE: hold_cnt <= 4'(HOLD_CYCLES - 1);
        HOLD: if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    Guess_Ready     = (state == WAIT_GUESS);
    Verdict_Valid   = (state == SCORE);
    Verdict_Correct = (state == SCORE) && correct;
    enable          = (state == DONE);
    Busy            = (state != IDLE);
  end

endmodule

// File: tb/tb_prime_round_scorer.sv
// Scoreboard bench: two scorers (default points and a 15-point build) share
// one stimulus stream; a reference model pushes expected verdicts and game
// results, and per-DUT monitors pop and compare.
module tb_prime_round_scorer;

  logic       Clk = 1'b0;
  logic       Reset, Start, Guess_Valid, Guess_Is_Prime;
  logic [2:0] Player_ID_In;
  logic [6:0] Number;

  logic       gr_a, vv_a, vc_a, en_a, busy_a;
  logic [3:0] rc_a;
  logic [6:0] rs_a, cs_a;
  logic [2:0] pid_a;
  logic       gr_b, vv_b, vc_b, en_b, busy_b;
  logic [3:0] rc_b;
  logic [6:0] rs_b, cs_b;
  logic [2:0] pid_b;

  prime_round_scorer dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Player_ID_In(Player_ID_In),
    .Guess_Valid(Guess_Valid), .Number(Number), .Guess_Is_Prime(Guess_Is_Prime),
    .Guess_Ready(gr_a), .Verdict_Valid(vv_a), .Verdict_Correct(vc_a),
    .Round_Count(rc_a), .Running_Score(rs_a), .Player_ID(pid_a),
    .Current_Score(cs_a), .enable(en_a), .Busy(busy_a));

  prime_round_scorer #(.CORRECT_PTS(15)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Player_ID_In(Player_ID_In),
    .Guess_Valid(Guess_Valid), .Number(Number), .Guess_Is_Prime(Guess_Is_Prime),
    .Guess_Ready(gr_b), .Verdict_Valid(vv_b), .Verdict_Correct(vc_b),
    .Round_Count(rc_b), .Running_Score(rs_b), .Player_ID(pid_b),
    .Current_Score(cs_b), .enable(en_b), .Busy(busy_b));

  always #5 Clk = ~Clk;

  typedef struct { bit correct; int score; int round; } verdict_t;
  typedef struct { int pid; int score; } game_t;

  verdict_t qa[$], qb[$];
  game_t    ga[$], gb[$];
  int m_score_a, m_score_b, m_round, m_pid;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit isprime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Trial-division cycles: divisors tried until one settles the question.
  function automatic int lat(input int n);
    int ds[5] = '{2, 3, 5, 7, 11};
    if (n < 2) return 1;
    for (int i = 0; i < 5; i++)
      if (ds[i] * ds[i] > n || n == ds[i] || n % ds[i] == 0) return i + 1;
    return 5;
  endfunction

  // Monitor for the default-points scorer.
  verdict_t cur_a; bit pend_a = 0, en_prev_a = 0;
  always begin
    @(negedge Clk);
    if (pend_a) begin
      chk("score_a", rs_a, cur_a.score);
      chk("round_a", rc_a, cur_a.round);
      pend_a = 0;
    end
    if (vv_a) begin
      chk("verdict_expected_a", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        cur_a = qa.pop_front();
        chk("correct_a", vc_a, cur_a.correct);
        pend_a = 1;
      end
    end
    if (en_a) begin
      chk("enable_width_a", en_prev_a, 0);
      chk("enable_expected_a", ga.size() > 0, 1);
      if (ga.size() > 0) begin
        game_t g;
        g = ga.pop_front();
        chk("player_id_a", pid_a, g.pid);
        chk("current_score_a", cs_a, g.score);
      end
    end
    en_prev_a = en_a;
  end

  // Monitor for the 15-point scorer.
  verdict_t cur_b; bit pend_b = 0, en_prev_b = 0;
  always begin
    @(negedge Clk);
    if (pend_b) begin
      chk("score_b", rs_b, cur_b.score);
      chk("round_b", rc_b, cur_b.round);
      pend_b = 0;
    end
    if (vv_b) begin
      chk("verdict_expected_b", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        cur_b = qb.pop_front();
        chk("correct_b", vc_b, cur_b.correct);
        pend_b = 1;
      end
    end
    if (en_b) begin
      chk("enable_width_b", en_prev_b, 0);
      chk("enable_expected_b", gb.size() > 0, 1);
      if (gb.size() > 0) begin
        game_t g;
        g = gb.pop_front();
        chk("player_id_b", pid_b, g.pid);
        chk("current_score_b", cs_b, g.score);
      end
    end
    en_prev_b = en_b;
  end

  task automatic start_game(input int id);
    int c = 0;
    while (busy_a && c < 50) begin @(negedge Clk); c++; end
    Start = 1'b1; Player_ID_In = 3'(id);
    @(negedge Clk);
    Start = 1'b0;
    if (id <= 4) begin
      m_pid = id; m_round = 0; m_score_a = 0; m_score_b = 0;
      chk("busy_after_start", busy_a, 1);
      chk("pid_latched", pid_a, id);
      chk("score_cleared", rs_a, 0);
      chk("cs_cleared", cs_a, 0);
    end else begin
      chk("bad_id_ignored", busy_a, 0);
      chk("bad_id_ignored_b", busy_b, 0);
    end
  endtask

  task automatic guess(input int n, input bit gp, input bit noise, input bit abort);
    int c = 0;
    bit ok;
    verdict_t v;
    while (!gr_a && c < 50) begin @(negedge Clk); c++; end
    chk("guess_ready", gr_a, 1);
    Number = 7'(n); Guess_Is_Prime = gp; Guess_Valid = 1'b1;
    ok = (isprime(n) == gp);
    if (ok) begin
      m_score_a = (m_score_a + 2 > 127) ? 127 : m_score_a + 2;
      m_score_b = (m_score_b + 15 > 127) ? 127 : m_score_b + 15;
    end else begin
      m_score_a = (m_score_a < 1) ? 0 : m_score_a - 1;
      m_score_b = (m_score_b < 1) ? 0 : m_score_b - 1;
    end
    m_round++;
    v.correct = ok; v.round = m_round;
    v.score = m_score_a; qa.push_back(v);
    v.score = m_score_b; qb.push_back(v);
    if (m_round == 10) begin
      ga.push_back('{m_pid, m_score_a});
      gb.push_back('{m_pid, m_score_b});
    end
    @(negedge Clk);
    if (noise) begin
      Start = 1'b1; Player_ID_In = 3'((m_pid + 1) % 5);
      Number = 7'($urandom_range(0, 127)); Guess_Is_Prime = ~gp;
    end else begin
      Guess_Valid = 1'b0;
    end
    if (abort) begin
      Reset = 1'b0;
      @(negedge Clk);
      Reset = 1'b1; Guess_Valid = 1'b0; Start = 1'b0;
      void'(qa.pop_back()); void'(qb.pop_back());
      m_round = 0; m_score_a = 0; m_score_b = 0;
      chk("abort_busy", busy_a, 0);
      chk("abort_score", rs_a, 0);
      chk("abort_round", rc_a, 0);
      chk("abort_pid", pid_a, 0);
      chk("abort_enable", en_a, 0);
      return;
    end
    c = 0;
    while (!vv_a && c < 20) begin c++; @(negedge Clk); end
    Guess_Valid = 1'b0; Start = 1'b0;
    chk("check_latency", c, lat(n));
    if (noise) chk("pid_kept", pid_a, m_pid);
  endtask

  task automatic finish_game();
    int c = 0;
    @(negedge Clk);
    chk("enable_pulse", en_a, 1);
    @(negedge Clk);
    while (busy_a && c < 20) begin c++; @(negedge Clk); end
    chk("hold_busy_cycles", c, 3);
  endtask

  task automatic run_game(input int id, input int mode);
    int n;
    bit gp, noise;
    start_game(id);
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 127);
      noise = 1'b0;
      case (mode)
        1:       gp = (i < 3) ? isprime(n) : !isprime(n);
        2:       gp = isprime(n);
        3:       begin gp = 1'($urandom); noise = 1'($urandom); end
        default: gp = 1'($urandom);
      endcase
      guess(n, gp, noise, 1'b0);
    end
    finish_game();
  endtask

  int fx_n[5]  = '{97, 91, 121, 1, 2};
  bit fx_gp[5] = '{1, 0, 0, 0, 1};

  initial begin
    Reset = 1'b0; Start = 1'b0; Player_ID_In = 3'd0; Guess_Valid = 1'b0;
    Number = 7'd0; Guess_Is_Prime = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", gr_a, 0);
    chk("rst_verdict", vv_a, 0);
    chk("rst_enable", en_a, 0);
    chk("rst_outputs", {rc_a, rs_a, pid_a, cs_a, vc_a}, 0);
    chk("rst_outputs_b", {busy_b, rc_b, rs_b, pid_b, cs_b}, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Fixed guesses first, then random rounds to finish the game.
    start_game(2);
    for (int i = 0; i < 5; i++) guess(fx_n[i], fx_gp[i], 1'b0, 1'b0);
    @(negedge Clk);
    chk("fixed_five_score", rs_a, 10);
    for (int i = 0; i < 5; i++) guess($urandom_range(0, 127), 1'($urandom), 1'b0, 1'b0);
    finish_game();

    run_game(1, 1);   // 3 correct then 7 wrong: floors at 0
    run_game(4, 2);   // all correct: 15-point build saturates at 127
    start_game(5);    // illegal ID ignored
    run_game(3, 3);   // Start/Guess_Valid noise during CHECK

    // Reset in the middle of round 4, then a normal game.
    start_game(0);
    for (int i = 0; i < 3; i++) guess($urandom_range(0, 127), 1'($urandom), 1'b0, 1'b0);
    guess(97, 1'b1, 1'b0, 1'b1);
    run_game(2, 0);

    for (int g = 0; g < 4; g++) run_game($urandom_range(0, 4), (g % 2) * 3);

    repeat (3) @(negedge Clk);
    chk("queues_drained", qa.size() + qb.size() + ga.size() + gb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
